// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble instruction, control-word layout,
// RV32I opcodes and operand-usage decode for hazard detection.
package pipe_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Control word layout, LSB first: regWEn, memRd, memWr, then ALU op bits.
  typedef struct packed {
    logic [4:0] aluOp;
    logic       memWr;
    logic       memRd;
    logic       regWEn;
  } ctrl_t;

  localparam int CTRL_REGWEN = 0;
  localparam int CTRL_MEMRD  = 1;
  localparam int CTRL_MEMWR  = 2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic {IDLE, STALL} hz_state_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_fsm.sv
// Load-use stall sequencer and front-end strobes; a redirect from EX
// overrides any stall and flushes IF/ID.
module hazard_fsm
  import pipe_pkg::*;
#(
  parameter int LU_STALL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hit_i,
  input  logic br_taken_i,
  output logic stall_o,
  output logic pc_en_o,
  output logic ifid_en_o,
  output logic ifid_flush_o
);

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The hit cycle is the first bubble, so STALL covers the remaining LU_STALL-1.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_o      = 1'b0;
    pc_en_o      = 1'b1;
    ifid_en_o    = 1'b1;
    ifid_flush_o = 1'b0;
    if (br_taken_i) begin
      state_d      = IDLE;
      cnt_d        = 2'd0;
      ifid_flush_o = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_i) begin
            stall_o = 1'b1;
            if (LU_STALL > 1) begin
              state_d = STALL;
              cnt_d   = 2'(LU_STALL - 1);
            end
          end
        end
        STALL: begin
          stall_o = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      endcase
      pc_en_o   = !stall_o;
      ifid_en_o = !stall_o;
    end
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use detection, branch flush and
// saturating stall/flush performance counters.
module id_ex_hazard_reg
  import pipe_pkg::*;
#(
  parameter int LU_STALL = 1,
  parameter int CTRL_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_ID,
  input  logic [31:0]       inst_ID,
  input  logic [31:0]       pc_ID,
  input  logic [31:0]       rs1_data_ID,
  input  logic [31:0]       rs2_data_ID,
  input  logic [31:0]       imm_ID,
  input  logic [CTRL_W-1:0] ctrl_ID,
  input  logic              br_taken_EX,
  output logic              valid_EX,
  output logic [31:0]       inst_EX_fwd,
  output logic [31:0]       pc_EX,
  output logic [31:0]       rs1_data_EX,
  output logic [31:0]       rs2_data_EX,
  output logic [31:0]       imm_EX,
  output logic [CTRL_W-1:0] ctrl_EX,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              validEx_q, validEx_d;
  logic [31:0]       instEx_q, instEx_d;
  logic [31:0]       pcEx_q, pcEx_d;
  logic [31:0]       rs1Ex_q, rs1Ex_d;
  logic [31:0]       rs2Ex_q, rs2Ex_d;
  logic [31:0]       immEx_q, immEx_d;
  logic [CTRL_W-1:0] ctrlEx_q, ctrlEx_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

  logic [4:0] rdEx, rs1Id, rs2Id;
  logic [6:0] opcodeId;
  logic       hit, stall, loadBubble;

  assign rdEx     = instEx_q[11:7];
  assign rs1Id    = inst_ID[19:15];
  assign rs2Id    = inst_ID[24:20];
  assign opcodeId = inst_ID[6:0];

  assign hit = valid_ID && validEx_q && ctrlEx_q[CTRL_MEMRD] && (rdEx != 5'd0) &&
               ((uses_rs1(opcodeId) && (rs1Id == rdEx)) ||
                (uses_rs2(opcodeId) && (rs2Id == rdEx)));

  hazard_fsm #(.LU_STALL(LU_STALL)) u_hazard_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .hit_i        (hit),
    .br_taken_i   (br_taken_EX),
    .stall_o      (stall),
    .pc_en_o      (pc_en),
    .ifid_en_o    (ifid_en),
    .ifid_flush_o (ifid_flush)
  );

  // stall is already masked by a redirect, so a killed hit is never counted.
  assign loadBubble = br_taken_EX || stall || !valid_ID;

  always_comb begin
    validEx_d = 1'b0;
    instEx_d  = NOP;
    pcEx_d    = 32'd0;
    rs1Ex_d   = 32'd0;
    rs2Ex_d   = 32'd0;
    immEx_d   = 32'd0;
    ctrlEx_d  = '0;
    if (!loadBubble) begin
      validEx_d = 1'b1;
      instEx_d  = inst_ID;
      pcEx_d    = pc_ID;
      rs1Ex_d   = rs1_data_ID;
      rs2Ex_d   = rs2_data_ID;
      immEx_d   = imm_ID;
      ctrlEx_d  = ctrl_ID;
    end
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stall && (stallCnt_q != {CNT_W{1'b1}})) stallCnt_d = stallCnt_q + CNT_W'(1);
    if (br_taken_EX && (flushCnt_q != {CNT_W{1'b1}})) flushCnt_d = flushCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validEx_q  <= 1'b0;
      instEx_q   <= NOP;
      pcEx_q     <= 32'd0;
      rs1Ex_q    <= 32'd0;
      rs2Ex_q    <= 32'd0;
      immEx_q    <= 32'd0;
      ctrlEx_q   <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      validEx_q  <= validEx_d;
      instEx_q   <= instEx_d;
      pcEx_q     <= pcEx_d;
      rs1Ex_q    <= rs1Ex_d;
      rs2Ex_q    <= rs2Ex_d;
      immEx_q    <= immEx_d;
      ctrlEx_q   <= ctrlEx_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign valid_EX    = validEx_q;
  assign inst_EX_fwd = instEx_q;
  assign pc_EX       = pcEx_q;
  assign rs1_data_EX = rs1Ex_q;
  assign rs2_data_EX = rs2Ex_q;
  assign imm_EX      = immEx_q;
  assign ctrl_EX     = ctrlEx_q;
  assign stall_cnt   = stallCnt_q;
  assign flush_cnt   = flushCnt_q;

endmodule
